hgcal_input_packer: RTL and testbench

Upstream front-end of the quantized HGCAL autoencoder. It accepts a beat-serial stream of raw unsigned sensor charges and quantizes each one to the 2-bit code that the layer-0 LUT neurons consume. It assembles one full frame of codes into a registered, packed input vector and presents that vector to the layer-0 fan-in wiring with a valid/ready handshake. Malformed frames are discarded and counted; they never reach the network.

---
 rtl/hgcal_input_packer_pkg.sv | 35 +++
 rtl/hgcal_input_packer_if.sv | 23 ++
 rtl/hgcal_quant_lane.sv | 13 +
 rtl/hgcal_input_packer.sv | 105 ++++++++++
 tb/tb_hgcal_input_packer.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hgcal_input_packer_pkg.sv
// Shared constants, FSM state type and quantizer for the HGCAL autoencoder
// front-end. The output de-quantizer stage imports this package as well.
package hgcal_input_packer_pkg;

   localparam int NUM_INPUTS = 48;
   localparam int IN_W       = 8;
   localparam int Q_W        = 2;
   localparam int SPB        = 4;
   localparam int SHIFT      = 6;

   localparam int BEATS  = NUM_INPUTS / SPB;
   localparam int PACK_W = NUM_INPUTS * Q_W;
   localparam int BEAT_W = SPB * Q_W;
   localparam int CNT_W  = $clog2(BEATS);
   localparam int DROP_W = 16;

   typedef enum logic {
      FILL   = 1'b0,
      RESYNC = 1'b1
   } state_e;

   // Shift-and-saturate with an explicit shift amount.
   function automatic logic [Q_W-1:0] quantize_sh(input logic [IN_W-1:0] x, input int sh);
      logic [IN_W-1:0] s;
      s = x >> sh;
      if (s > IN_W'((1 << Q_W) - 1)) return '1;
      return s[Q_W-1:0];
   endfunction

   // Quantizer as seen by the layer-0 LUT neurons.
   function automatic logic [Q_W-1:0] quantize(input logic [IN_W-1:0] x);
      return quantize_sh(x, SHIFT);
   endfunction

endpackage

// File: rtl/hgcal_input_packer_if.sv
// Beat-serial sample input and packed-frame output handshakes.
interface hgcal_input_packer_if;
   import hgcal_input_packer_pkg::*;

   logic                  s_valid;
   logic                  s_ready;
   logic [SPB*IN_W-1:0]   s_data;
   logic                  s_last;
   logic                  m_valid;
   logic                  m_ready;
   logic [PACK_W-1:0]     m_data;

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_data
   );

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_data
   );

endinterface

// File: rtl/hgcal_quant_lane.sv
// One raw sample to one quantized code: shift right, then clamp to the code range.
module hgcal_quant_lane
   import hgcal_input_packer_pkg::*;
#(
   parameter int SHIFT_AMT = SHIFT
) (
   input  logic [IN_W-1:0] x_i,
   output logic [Q_W-1:0]  q_o
);

   assign q_o = quantize_sh(x_i, SHIFT_AMT);

endmodule

// File: rtl/hgcal_input_packer.sv
// Quantizes a beat-serial stream of sensor charges and packs one full frame
// of codes into a registered vector for the layer-0 fan-in. Malformed frames
// are discarded and counted.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   FILL   | assembling a frame, beat_q = index of the next beat
//   RESYNC | frame lost its last marker; drop beats until one with s_last
module hgcal_input_packer
   import hgcal_input_packer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   hgcal_input_packer_if.slave   bus,
   output logic                  err_frame,
   output logic [DROP_W-1:0]     drop_cnt
);

   logic [BEAT_W-1:0] codes;
   state_e            state_q;
   logic [CNT_W-1:0]  beat_q;
   logic [PACK_W-1:0] buf_q;
   logic [PACK_W-1:0] buf_d;
   logic [PACK_W-1:0] m_data_q;
   logic              m_valid_q;
   logic              err_q;
   logic [DROP_W-1:0] drop_q;
   logic              run_q;
   logic              last_beat;
   logic              s_ready_c;
   logic              accept;

   for (genvar j = 0; j < SPB; j++) begin : g_lane
      hgcal_quant_lane #(.SHIFT_AMT(SHIFT)) u_lane (
         .x_i (bus.s_data[j*IN_W +: IN_W]),
         .q_o (codes[j*Q_W +: Q_W])
      );
   end

   assign last_beat = (beat_q == CNT_W'(BEATS - 1));

   // Only the final beat can be stalled: it is the one that overwrites m_data.
   always_comb begin
      s_ready_c = 1'b0;
      if (run_q) begin
         if (state_q == RESYNC) s_ready_c = 1'b1;
         else                   s_ready_c = !last_beat || !m_valid_q || bus.m_ready;
      end
   end

   assign accept = bus.s_valid && s_ready_c;

   // Assembly buffer with the current beat's codes merged into its slot.
   always_comb begin
      buf_d = buf_q;
      buf_d[int'(beat_q)*BEAT_W +: BEAT_W] = codes;
   end

   // Frame FSM, beat counter, output register and discard bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FILL;
         beat_q    <= '0;
         buf_q     <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         err_q     <= 1'b0;
         drop_q    <= '0;
         run_q     <= 1'b0;
      end else begin
         run_q <= 1'b1;
         err_q <= 1'b0;
         if (m_valid_q && bus.m_ready) m_valid_q <= 1'b0;
         if (accept) begin
            case (state_q)
               FILL: begin
                  buf_q <= buf_d;
                  if (!last_beat && !bus.s_last) begin
                     beat_q <= beat_q + CNT_W'(1);
                  end else if (last_beat && bus.s_last) begin
                     m_data_q  <= buf_d;
                     m_valid_q <= 1'b1;
                     beat_q    <= '0;
                  end else begin
                     err_q  <= 1'b1;
                     beat_q <= '0;
                     if (drop_q != '1) drop_q <= drop_q + DROP_W'(1);
                     if (last_beat) state_q <= RESYNC;
                  end
               end
               default: begin
                  if (bus.s_last) state_q <= FILL;
               end
            endcase
         end
      end
   end

   assign bus.s_ready = s_ready_c;
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;
   assign err_frame   = err_q;
   assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Directed bench for the HGCAL input packer: reset, framing, quantization,
// backpressure and malformed-frame recovery.
module tb_hgcal_input_packer;
   import hgcal_input_packer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        err_frame;
   logic [15:0] drop_cnt;
   logic [7:0]  lx;
   logic [1:0]  lq;
   int          n_checks = 0;
   int          n_fail = 0;
   int          err_seen = 0;
   int          cyc = 0;

   hgcal_input_packer_if bus();

   hgcal_input_packer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .err_frame (err_frame),
      .drop_cnt  (drop_cnt)
   );

   hgcal_quant_lane #(.SHIFT_AMT(4)) u_lane4 (
      .x_i (lx),
      .q_o (lq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (err_frame === 1'b1) err_seen++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] pat(int seed, int k);
      if (seed == 0) return 8'hFF;
      return 8'(k*seed + seed*3);
   endfunction

   function automatic logic [1:0] q_ref(logic [7:0] x);
      int v;
      v = x / 64;
      return (v > 3) ? 2'd3 : 2'(v);
   endfunction

   function automatic logic [95:0] exp_frame(int seed);
      logic [95:0] r;
      r = '0;
      for (int k = 0; k < 48; k++) r[k*2 +: 2] = q_ref(pat(seed, k));
      return r;
   endfunction

   function automatic logic [31:0] beat_data(int seed, int b);
      logic [31:0] d;
      for (int j = 0; j < 4; j++) d[j*8 +: 8] = pat(seed, b*4 + j);
      return d;
   endfunction

   // Called at a negedge; returns at the negedge following the handshake.
   task automatic beat(input logic [31:0] d, input logic l);
      int w;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = l;
      #1;
      w = 0;
      while (bus.s_ready !== 1'b1 && w < 100) begin
         @(negedge clk); #1;
         w++;
      end
      n_checks++;
      if (w >= 100) begin
         $display("FAIL beat_timeout: s_ready=%b required 1", bus.s_ready);
         n_fail++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_frame(input int seed, input int nb, input int last_at, input bit idle_after);
      for (int b = 0; b < nb; b++) beat(beat_data(seed, b), (b == last_at));
      if (idle_after) begin
         bus.s_valid = 1'b0;
         bus.s_last  = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_last  = 1'b0;
      bus.s_data  = '1;
      bus.m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_checks++;
         if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || drop_cnt !== 16'd0) begin
            $display("FAIL reset_hold: s_ready=%b m_valid=%b drop=%0d required 0 0 0",
                     bus.s_ready, bus.m_valid, drop_cnt);
            n_fail++;
         end
      end
      bus.s_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      n_checks++;
      if (bus.s_ready !== 1'b1 || bus.m_data !== 96'd0 || err_frame !== 1'b0) begin
         $display("FAIL reset_release: s_ready=%b m_data=%h err=%b required 1 0 0",
                  bus.s_ready, bus.m_data, err_frame);
         n_fail++;
      end
      @(negedge clk);
   endtask

   task automatic test_single_frame();
      int e0;
      e0 = err_seen;
      bus.m_ready = 1'b1;
      send_frame(0, 12, 11, 1);
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== {96{1'b1}}) begin
         $display("FAIL single_frame: m_valid=%b m_data=%h required 1 all-ones", bus.m_valid, bus.m_data);
         n_fail++;
      end
      @(negedge clk);
      n_checks++;
      if (bus.m_valid !== 1'b0) begin
         $display("FAIL single_clear: m_valid=%b required 0", bus.m_valid);
         n_fail++;
      end
      n_checks++;
      if (err_seen != e0) begin
         $display("FAIL single_err: err pulses=%0d required 0", err_seen - e0);
         n_fail++;
      end
   endtask

   task automatic test_quant();
      beat({8'hC0, 8'h80, 8'h40, 8'h3F}, 1'b0);
      for (int b = 1; b < 12; b++) beat(32'd0, (b == 11));
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data[7:0] !== 8'hE4 || bus.m_data[95:8] !== 88'd0) begin
         $display("FAIL quant_codes: m_valid=%b m_data=%h required 1 ...e4", bus.m_valid, bus.m_data);
         n_fail++;
      end
      lx = 8'h50; #1;
      n_checks++;
      if (lq !== 2'd3) begin $display("FAIL quant_sat: code=%0d required 3", lq); n_fail++; end
      lx = 8'h3F; #1;
      n_checks++;
      if (lq !== 2'd3) begin $display("FAIL quant_edge: code=%0d required 3", lq); n_fail++; end
      lx = 8'h2F; #1;
      n_checks++;
      if (lq !== 2'd2) begin $display("FAIL quant_mid: code=%0d required 2", lq); n_fail++; end
      lx = 8'h0F; #1;
      n_checks++;
      if (lq !== 2'd0) begin $display("FAIL quant_zero: code=%0d required 0", lq); n_fail++; end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      bus.m_ready = 1'b0;
      send_frame(3, 12, 11, 1);
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp_frame(3)) begin
         $display("FAIL bp_frame_a: m_valid=%b m_data=%h required 1 %h", bus.m_valid, bus.m_data, exp_frame(3));
         n_fail++;
      end
      send_frame(7, 11, 99, 0);
      bus.s_valid = 1'b1;
      bus.s_data  = beat_data(7, 11);
      bus.s_last  = 1'b1;
      #1;
      n_checks++;
      if (bus.s_ready !== 1'b0) begin
         $display("FAIL bp_stall: s_ready=%b required 0", bus.s_ready);
         n_fail++;
      end
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1 || bus.m_data !== exp_frame(3)) begin
         $display("FAIL bp_hold: s_ready=%b m_valid=%b m_data=%h required 0 1 %h",
                  bus.s_ready, bus.m_valid, bus.m_data, exp_frame(3));
         n_fail++;
      end
      bus.m_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.s_ready !== 1'b1 || bus.m_data !== exp_frame(3)) begin
         $display("FAIL bp_release_a: s_ready=%b m_data=%h required 1 %h", bus.s_ready, bus.m_data, exp_frame(3));
         n_fail++;
      end
      @(posedge clk);
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp_frame(7)) begin
         $display("FAIL bp_frame_b: m_valid=%b m_data=%h required 1 %h", bus.m_valid, bus.m_data, exp_frame(7));
         n_fail++;
      end
      @(negedge clk);
      n_checks++;
      if (bus.m_valid !== 1'b0) begin
         $display("FAIL bp_drain: m_valid=%b required 0", bus.m_valid);
         n_fail++;
      end
   endtask

   task automatic test_early_last();
      int e0;
      e0 = err_seen;
      bus.m_ready = 1'b1;
      send_frame(5, 6, 5, 1);
      n_checks++;
      if (err_frame !== 1'b1 || bus.m_valid !== 1'b0) begin
         $display("FAIL early_err: err=%b m_valid=%b required 1 0", err_frame, bus.m_valid);
         n_fail++;
      end
      @(negedge clk);
      n_checks++;
      if (err_frame !== 1'b0 || drop_cnt !== 16'd1) begin
         $display("FAIL early_count: err=%b drop=%0d required 0 1", err_frame, drop_cnt);
         n_fail++;
      end
      send_frame(9, 12, 11, 1);
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp_frame(9)) begin
         $display("FAIL early_next: m_valid=%b m_data=%h required 1 %h", bus.m_valid, bus.m_data, exp_frame(9));
         n_fail++;
      end
      n_checks++;
      if (err_seen - e0 != 1) begin
         $display("FAIL early_pulses: pulses=%0d required 1", err_seen - e0);
         n_fail++;
      end
   endtask

   task automatic test_missing_last();
      int e0;
      e0 = err_seen;
      bus.m_ready = 1'b1;
      send_frame(11, 12, 99, 0);
      n_checks++;
      if (err_frame !== 1'b1 || drop_cnt !== 16'd2) begin
         $display("FAIL missing_err: err=%b drop=%0d required 1 2", err_frame, drop_cnt);
         n_fail++;
      end
      send_frame(6, 3, 2, 1);
      n_checks++;
      if (bus.m_valid !== 1'b0 || drop_cnt !== 16'd2) begin
         $display("FAIL missing_junk: m_valid=%b drop=%0d required 0 2", bus.m_valid, drop_cnt);
         n_fail++;
      end
      send_frame(13, 12, 11, 1);
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp_frame(13)) begin
         $display("FAIL missing_next: m_valid=%b m_data=%h required 1 %h", bus.m_valid, bus.m_data, exp_frame(13));
         n_fail++;
      end
      n_checks++;
      if (err_seen - e0 != 1) begin
         $display("FAIL missing_pulses: pulses=%0d required 1", err_seen - e0);
         n_fail++;
      end
   endtask

   task automatic test_back_to_back();
      int c0;
      bus.m_ready = 1'b1;
      c0 = cyc;
      send_frame(2, 12, 11, 0);
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp_frame(2)) begin
         $display("FAIL b2b_first: m_valid=%b m_data=%h required 1 %h", bus.m_valid, bus.m_data, exp_frame(2));
         n_fail++;
      end
      send_frame(4, 12, 11, 1);
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp_frame(4)) begin
         $display("FAIL b2b_second: m_valid=%b m_data=%h required 1 %h", bus.m_valid, bus.m_data, exp_frame(4));
         n_fail++;
      end
      n_checks++;
      if (cyc - c0 != 24) begin
         $display("FAIL b2b_cycles: cycles=%0d required 24", cyc - c0);
         n_fail++;
      end
   endtask

   task automatic test_mid_reset();
      bus.m_ready = 1'b1;
      send_frame(10, 5, 99, 1);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || drop_cnt !== 16'd0 || err_frame !== 1'b0) begin
         $display("FAIL midrst_state: s_ready=%b m_valid=%b drop=%0d err=%b required 0 0 0 0",
                  bus.s_ready, bus.m_valid, drop_cnt, err_frame);
         n_fail++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(8, 12, 11, 1);
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp_frame(8) || drop_cnt !== 16'd0) begin
         $display("FAIL midrst_next: m_valid=%b m_data=%h drop=%0d required 1 %h 0",
                  bus.m_valid, bus.m_data, drop_cnt, exp_frame(8));
         n_fail++;
      end
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;
      lx = 8'd0;
      test_reset();
      test_single_frame();
      test_quant();
      test_backpressure();
      test_early_last();
      test_missing_last();
      test_back_to_back();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
